shift_sched: RTL and testbench
==============================

SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 SHALL have clock: clock, input, 1, rising-edge system clock.
REQ-002 SHALL have reset: reset, input, 1, asynchronous, active-low; clock clock.
REQ-003 SHALL have req0 / req1: input, 1 each, request from requester 0 / 1; held high until granted.
REQ-004 SHALL have data0 / data1: input, 8 each, word offered by requester 0 / 1; stable while its req is high.
REQ-005 SHALL have gnt0 / gnt1: output, 1 each, one-cycle accept pulse to requester 0 / 1.
REQ-006 SHALL have ser_out: output, 1, serial bit currently driven into the shift chain.
REQ-007 SHALL have par_out: output, 8, shift-chain contents {q7..q0}.
REQ-008 SHALL have valid: output, 1, one-cycle pulse; par_out holds a complete word.
REQ-009 SHALL have owner: output, 1, index of the requester whose word is in flight or was last delivered.
REQ-010 SHALL have busy: output, 1, high in every state except IDLE.

Function
REQ-011 SHALL implement states IDLE, SHIFT, DONE; all outputs registered.
REQ-012 In IDLE with no req sampled high, the block SHALL remain in IDLE with gnt0, gnt1, valid and ser_out at 0.
REQ-013 In IDLE with exactly one req high at edge E0, the block SHALL latch that requester's data, set owner, load cnt=0, enter SHIFT, and assert that requester's gnt for the single cycle after E0.
REQ-014 With both reqs high in IDLE, the block SHALL grant the requester that was not last served (round-robin).
REQ-015 In SHIFT, ser_out SHALL equal latched_data[7-cnt], MSB first; the chain SHALL capture ser_out into q0 and move q(n-1) into q(n) on every edge.
REQ-016 At the edge where cnt=7, the block SHALL enter DONE; cnt SHALL be 3 bits and never wrap within one word.
REQ-017 After edge E0+8, par_out SHALL equal the latched word, and valid SHALL be high for exactly that one cycle in DONE.
REQ-018 DONE SHALL return to IDLE on the next edge, and last-served SHALL update to owner; the earliest next accept is edge E0+10.
REQ-019 A req arriving while busy SHALL be ignored until IDLE; it is not lost provided it is held.
REQ-020 A req dropped before it is sampled in IDLE SHALL receive no grant.
REQ-021 par_out SHALL hold its value in IDLE and DONE, and may change only in SHIFT; ser_out SHALL be 0 outside SHIFT.

Reset
REQ-022 While reset=0, the block SHALL force state=IDLE, cnt=0, latched data=0, chain q0..q7=0, gnt0=gnt1=valid=ser_out=busy=0, and owner=0.
REQ-023 While reset=0, last-served SHALL be forced to 1, so that req0 wins the first tie.
REQ-024 Reset asserted mid-SHIFT or DONE SHALL discard the word, with no valid and no further gnt.

Structure
REQ-025 The shared package SHALL hold the state enum (IDLE, SHIFT, DONE), the constant WIDTH=8 and the constant CNT_W=3.
REQ-026 The block SHALL contain one sub-module, shift8: clock, reset (async active-low), si, q[7:0], serial-in shift chain.
REQ-027 The FSM, arbiter and counter SHALL reside in shift_sched.

Verification
REQ-028 Single request: req0=1, data0=8'hA5 -> gnt0 pulses 1 cycle after accept; ser_out = 1,0,1,0,0,1,0,1; valid at E0+8 with par_out=8'hA5; owner=0.
REQ-029 Tie after reset: req0=req1=1, data0=8'h3C, data1=8'hC3 -> 8'h3C delivered first with owner=0, then 8'hC3 with owner=1; gnt pulses exactly 10 cycles apart.
REQ-030 Round-robin: req1 served (8'h01), then both reqs high -> req0 granted next.
REQ-031 Busy hold-off: req1 raised 3 cycles into req0's SHIFT -> no gnt1 until IDLE; gnt1 at E0+10.
REQ-032 Reset mid-shift: reset=0 at E0+4 -> par_out=0, valid never asserted, state IDLE; req0 held re-granted after release.
REQ-033 Withdrawn request: req1 pulsed for 1 cycle while busy -> no gnt1, no transfer.

Source files
------------

// File: rtl/shift_sched_pkg.sv
// rtl/shift_sched_pkg.sv - Shared types and constants for the shift scheduler.
package shift_sched_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Bit driven at shift position idx; words go out MSB first.
  function automatic logic tx_bit(input logic [WIDTH-1:0] word, input logic [CNT_W-1:0] idx);
    return word[CNT_W'(WIDTH - 1) - idx];
  endfunction

endpackage

// File: rtl/shift_sched_if.sv
// rtl/shift_sched_if.sv - Requester-side handshake bundle: two req/data/gnt channels.
interface shift_sched_if;
  import shift_sched_pkg::*;

  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;

  modport master (output req0, req1, data0, data1, input gnt0, gnt1);
  modport slave  (input req0, req1, data0, data1, output gnt0, gnt1);

endinterface

// File: rtl/shift_sched_shift8.sv
// rtl/shift_sched_shift8.sv - Serial-in shift chain; si enters q0 and every stage moves up each edge.
module shift8
  import shift_sched_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             si,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= {q[WIDTH-2:0], si};
  end

endmodule

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - Round-robin arbiter for two requesters that serialises the winner's
// word MSB first into an 8-stage shift chain and flags the completed parallel word.
module shift_sched
  import shift_sched_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  shift_sched_if.slave     bus,
  output logic             ser_out,
  output logic [WIDTH-1:0] par_out,
  output logic             valid,
  output logic             owner,
  output logic             busy
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] data_q, data_nx;
  logic [WIDTH-1:0] chain_q, par_nx;
  logic             last_q, last_nx;
  logic             owner_nx, gnt0_nx, gnt1_nx, ser_nx, valid_nx, busy_nx, pick;

  shift8 u_chain (
    .clock (clock),
    .reset (reset),
    .si    (ser_out),
    .q     (chain_q)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    data_nx  = data_q;
    last_nx  = last_q;
    owner_nx = owner;
    par_nx   = par_out;
    gnt0_nx  = 1'b0;
    gnt1_nx  = 1'b0;
    ser_nx   = 1'b0;
    valid_nx = 1'b0;
    // On a tie the requester not served last wins; otherwise whoever is asking.
    pick     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
          owner_nx = pick;
          data_nx  = pick ? bus.data1 : bus.data0;
          gnt0_nx  = ~pick;
          gnt1_nx  = pick;
          ser_nx   = tx_bit(data_nx, '0);
        end
      end
      SHIFT: begin
        // The chain runs freely; par_out mirrors its next value only while shifting.
        par_nx = (chain_q << 1) | WIDTH'(ser_out);
        if (cnt == CNT_W'(WIDTH - 1)) begin
          state_nx = DONE;
          valid_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
          ser_nx = tx_bit(data_q, cnt + 1'b1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        last_nx  = owner;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      last_q   <= 1'b1;
      owner    <= 1'b0;
      par_out  <= '0;
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      ser_out  <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      data_q   <= data_nx;
      last_q   <= last_nx;
      owner    <= owner_nx;
      par_out  <= par_nx;
      bus.gnt0 <= gnt0_nx;
      bus.gnt1 <= gnt1_nx;
      ser_out  <= ser_nx;
      valid    <= valid_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - Self-checking bench: vector table, directed corner sequences,
// random traffic against a transaction-level reference model.
module tb_shift_sched;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ser_out, valid, owner, busy;
  logic [7:0] par_out;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;

  shift_sched_if bus ();

  shift_sched dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .ser_out (ser_out),
    .par_out (par_out),
    .valid   (valid),
    .owner   (owner),
    .busy    (busy)
  );

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Reference model: a transfer accepted at edge e0 occupies edges e0..e0+9.
  int         m_n = 0, m_e0 = 0, m_ready = 0;
  bit         m_has = 0, m_last = 1, m_owner = 0;
  logic [7:0] m_word = '0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_has = 0; m_last = 1; m_owner = 0; m_ready = 0; m_word = '0;
    end else begin
      m_n++;
      if (m_n >= m_ready && (bus.req0 || bus.req1)) begin
        m_owner = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        m_word  = m_owner ? bus.data1 : bus.data0;
        m_last  = m_owner;
        m_e0    = m_n;
        m_ready = m_n + 10;
        m_has   = 1;
      end
    end
  end

  always @(negedge clock) begin : model_check
    int         k;
    logic [5:0] exp_ctl;
    if (reset) begin
      k = m_has ? (m_n - m_e0) : 1000;
      exp_ctl = {m_has && k == 0 && !m_owner, m_has && k == 0 && m_owner, k <= 8,
                 k <= 7 ? m_word[7 - (k % 8)] : 1'b0, k == 8, m_owner};
      check("model_ctl{g0,g1,busy,ser,valid,owner}",
            32'({bus.gnt0, bus.gnt1, busy, ser_out, valid, owner}), 32'(exp_ctl));
      if (k >= 8) check("model_par_out", 32'(par_out), 32'(m_has ? m_word : 8'h00));
    end
  end

  typedef struct {
    logic       r0, r1;
    logic [7:0] d0, d1;
    logic       exp_owner;
    logic [7:0] exp_word;
  } vec_t;
  vec_t vecs[8];

  task automatic wait_gnt(input string name, input bit which, output int at);
    int w = 0;
    while (!(which ? bus.gnt1 : bus.gnt0) && w < 40) begin
      tick();
      w++;
    end
    check(name, 32'(w < 40), 32'd1);
    at = cyc;
  endtask

  task automatic run_vec(input int idx);
    int         w = 0;
    logic [7:0] bits;
    bus.req0 = vecs[idx].r0; bus.req1 = vecs[idx].r1;
    bus.data0 = vecs[idx].d0; bus.data1 = vecs[idx].d1;
    while (!(bus.gnt0 || bus.gnt1) && w < 40) begin
      tick();
      w++;
    end
    check("vec_gnt_seen", 32'(w < 40), 32'd1);
    check("vec_gnt_{g1,g0}", 32'({bus.gnt1, bus.gnt0}), vecs[idx].exp_owner ? 32'd2 : 32'd1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bits[7] = ser_out;
    for (int k = 1; k < 8; k++) begin
      tick();
      bits[7 - k] = ser_out;
    end
    tick();
    check("vec_valid", 32'(valid), 32'd1);
    check("vec_par_out", 32'(par_out), 32'(vecs[idx].exp_word));
    check("vec_serial_bits", 32'(bits), 32'(vecs[idx].exp_word));
    check("vec_owner", 32'(owner), 32'(vecs[idx].exp_owner));
    tick();
    check("vec_idle_after", 32'({valid, busy}), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin : main
    int t0, t1, seen;
    vecs[0] = '{1, 0, 8'hA5, 8'h00, 0, 8'hA5};
    vecs[1] = '{0, 1, 8'h00, 8'h01, 1, 8'h01};
    vecs[2] = '{1, 1, 8'h3C, 8'hC3, 0, 8'h3C};
    vecs[3] = '{1, 1, 8'h5A, 8'h96, 1, 8'h96};
    vecs[4] = '{0, 1, 8'h00, 8'hFF, 1, 8'hFF};
    vecs[5] = '{1, 1, 8'h00, 8'h80, 0, 8'h00};
    vecs[6] = '{1, 0, 8'h81, 8'h00, 0, 8'h81};
    vecs[7] = '{1, 1, 8'h12, 8'h34, 1, 8'h34};
    bus.req0 = 0; bus.req1 = 0; bus.data0 = 8'h5A; bus.data1 = 8'hA5;

    tick();
    tick();
    check("reset_par_out", 32'(par_out), 32'd0);
    check("reset_ctl{g0,g1,ser,valid,busy,owner}",
          32'({bus.gnt0, bus.gnt1, ser_out, valid, busy, owner}), 32'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(i);

    // Tie straight after reset: req0 first, req1 exactly ten cycles later.
    do_reset();
    bus.req0 = 1; bus.req1 = 1; bus.data0 = 8'h3C; bus.data1 = 8'hC3;
    wait_gnt("tie_gnt0", 0, t0);
    bus.req0 = 0;
    wait_gnt("tie_gnt1", 1, t1);
    bus.req1 = 0;
    check("tie_gnt_spacing", 32'(t1 - t0), 32'd10);
    repeat (8) tick();
    check("tie_second_word", 32'({valid, owner, par_out}), 32'({2'b11, 8'hC3}));
    tick();

    // Request raised mid-shift waits for IDLE.
    bus.req0 = 1; bus.data0 = 8'h5B;
    wait_gnt("holdoff_gnt0", 0, t0);
    bus.req0 = 0;
    repeat (3) tick();
    bus.req1 = 1; bus.data1 = 8'h77;
    wait_gnt("holdoff_gnt1", 1, t1);
    bus.req1 = 0;
    check("holdoff_spacing", 32'(t1 - t0), 32'd10);
    repeat (10) tick();

    // Reset mid-shift discards the word; the held request is granted again.
    bus.req0 = 1; bus.data0 = 8'hE7;
    wait_gnt("rst_first_gnt0", 0, t0);
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("rst_mid_par_out", 32'(par_out), 32'd0);
    check("rst_mid_ctl{g0,ser,valid,busy}", 32'({bus.gnt0, ser_out, valid, busy}), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    check("rst_held_ctl{valid,busy}", 32'({valid, busy}), 32'd0);
    wait_gnt("rst_regrant_gnt0", 0, t1);
    bus.req0 = 0;
    repeat (12) tick();

    // One-cycle req1 pulse while busy earns nothing.
    bus.req0 = 1; bus.data0 = 8'h42;
    wait_gnt("withdraw_gnt0", 0, t0);
    bus.req0 = 0;
    repeat (2) tick();
    bus.req1 = 1; bus.data1 = 8'h99;
    tick();
    bus.req1 = 0;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      seen += int'(bus.gnt1);
    end
    check("withdraw_no_gnt1", 32'(seen), 32'd0);

    // Random traffic, checked by the reference model every cycle.
    for (int c = 0; c < 800; c++) begin
      tick();
      if (bus.req0) begin
        if (bus.gnt0 || $urandom_range(0, 24) == 0) bus.req0 = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.data0 = 8'($urandom);
        bus.req0 = 1;
      end
      if (bus.req1) begin
        if (bus.gnt1 || $urandom_range(0, 24) == 0) bus.req1 = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.data1 = 8'($urandom);
        bus.req1 = 1;
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
